// File: rtl/event_hub.sv
// ---------------------------------------------------------------------------
// event_hub
//
// Collects single-cycle event pulses on NUM_CH channels and lets one waiter
// block until an event arrives on a chosen channel.
//
//   * Per-channel saturating pending counters (CNT_W bits each).
//   * A three-state waiter FSM (IDLE -> ARMED -> DONE -> IDLE).
//   * A registered monitor that reports which channels fired last edge.
//
// Parameters
//   NUM_CH  number of event channels (2..32)
//   CNT_W   width of each pending counter
//   STICKY  0 = edge mode: only triggers after arming complete a wait,
//               and pending is informational only
//           1 = sticky mode: a stored pending trigger also completes a
//               wait, and one trigger is consumed per completed wait
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous, active-low reset
//   trig         event pulses, one trigger per high bit per edge
//   wait_valid   waiter request to block on wait_ch
//   wait_ch      requested channel (values >= NUM_CH never complete)
//   wait_ready   request can be accepted this cycle (FSM in IDLE)
//   wait_cancel  abandon an armed wait
//   wait_done    one-cycle pulse, armed wait completed
//   mon_valid    some trig bit was high at the previous edge
//   mon_ch       lowest channel that triggered at the previous edge
//   mon_multi    more than one channel triggered at the previous edge
//   pending      per-channel counters, channel 0 in the LSBs
//   done_ts      (only with EVENT_HUB_TIMESTAMP_EN) free-running timestamp
//                captured at the edge that entered DONE
//
// Optional feature macro: EVENT_HUB_TIMESTAMP_EN
// ---------------------------------------------------------------------------
module event_hub #(
   parameter int NUM_CH = 5,
   parameter int CNT_W  = 4,
   parameter int STICKY = 0,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         trig,
   input  logic                      wait_valid,
   input  logic [CH_W-1:0]           wait_ch,
   output logic                      wait_ready,
   input  logic                      wait_cancel,
   output logic                      wait_done,
   output logic                      mon_valid,
   output logic [CH_W-1:0]           mon_ch,
   output logic                      mon_multi,
   output logic [NUM_CH*CNT_W-1:0]   pending
`ifdef EVENT_HUB_TIMESTAMP_EN
   ,
   output logic [31:0]               done_ts
`endif
);

   // Channel selects are done on vectors padded up to the full range of
   // the channel index, so an out-of-range armed channel reads a constant
   // zero and simply never completes.
   localparam int SEL_W = 1 << CH_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CH_W-1:0]     arm_ch;
   logic                take;
   logic                hit;
   logic [SEL_W-1:0]    avail_ext;
   logic [NUM_CH-1:0]   consume;
   logic [CNT_W-1:0]    cnt     [NUM_CH];
   logic [CNT_W-1:0]    cnt_nxt [NUM_CH];
   logic [CNT_W:0]      cnt_sum [NUM_CH];
   logic                mon_valid_nxt;
   logic [CH_W-1:0]     mon_ch_nxt;
   logic                mon_multi_nxt;

   // A channel can complete a wait if it fires this edge, or, in sticky
   // mode, if it already has a stored trigger.
   always_comb begin
      avail_ext = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         avail_ext[i] = trig[i] | ((STICKY != 0) && (cnt[i] != '0));
      end
      hit = avail_ext[arm_ch];
   end

   // Waiter FSM next state. Cancel wins over a completing trigger, so the
   // trigger is left in the counter.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (wait_valid) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (wait_cancel) begin
               state_nxt = IDLE;
            end else if (hit) begin
               state_nxt = DONE;
               take      = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign wait_ready = (state == IDLE);
   assign wait_done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         arm_ch <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && wait_valid) begin
            arm_ch <= wait_ch;
         end
      end
   end

   // Only sticky mode removes a trigger from the counter on completion.
   always_comb begin
      consume = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         consume[i] = (STICKY != 0) && take && (arm_ch == CH_W'(i));
      end
   end

   // Counter update is pending + trig - consume computed one bit wider.
   // Consume only happens when the counter is non-zero or the channel
   // fires, so the sum never goes negative; the extra top bit flags
   // overflow, which saturates at all ones.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_sum[i] = {1'b0, cnt[i]} + (CNT_W+1)'(trig[i])
                      - (CNT_W+1)'(consume[i]);
         cnt_nxt[i] = cnt_sum[i][CNT_W] ? '1 : cnt_sum[i][CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst_n) begin
            cnt[i] <= '0;
         end else begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign pending[g*CNT_W +: CNT_W] = cnt[g];
   end

   // Monitor: lowest firing channel found by scanning from the top down,
   // multi detected by clearing the lowest set bit and testing the rest.
   always_comb begin
      mon_valid_nxt = |trig;
      mon_ch_nxt    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (trig[i]) begin
            mon_ch_nxt = CH_W'(i);
         end
      end
      mon_multi_nxt = |(trig & (trig - NUM_CH'(1)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mon_valid <= 1'b0;
         mon_ch    <= '0;
         mon_multi <= 1'b0;
      end else begin
         mon_valid <= mon_valid_nxt;
         mon_ch    <= mon_ch_nxt;
         mon_multi <= mon_multi_nxt;
      end
   end

`ifdef EVENT_HUB_TIMESTAMP_EN
   logic [31:0] ts;

   // Free-running wrap-around timestamp; the value present at the edge
   // that completes a wait is stored and held until the next completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts      <= '0;
         done_ts <= '0;
      end else begin
         ts <= ts + 32'd1;
         if (take) begin
            done_ts <= ts;
         end
      end
   end
`endif

endmodule

// File: tb/tb_event_hub.sv
// ---------------------------------------------------------------------------
// tb_event_hub
//
// Drives one edge-mode and one sticky-mode event_hub with identical inputs.
// Each driven cycle runs a small behavioural model of both instances and
// queues the expected post-edge outputs; a checker pops them one time unit
// after every rising edge. Directed scenarios add a few fixed-value checks.
// ---------------------------------------------------------------------------
module tb_event_hub;

   localparam int NUM_CH = 5;
   localparam int CNT_W  = 4;
   localparam int CH_W   = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  trig;
   logic        wait_valid;
   logic [2:0]  wait_ch;
   logic        wait_cancel;

   logic        e_ready, e_done, e_mv, e_mm;
   logic [2:0]  e_mch;
   logic [19:0] e_pend;
   logic        s_ready, s_done, s_mv, s_mm;
   logic [2:0]  s_mch;
   logic [19:0] s_pend;
`ifdef EVENT_HUB_TIMESTAMP_EN
   logic [31:0] e_ts, s_ts;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]       ready;
      logic [1:0]       done;
      logic [1:0]       mv;
      logic [1:0]       mm;
      logic [1:0][2:0]  mch;
      logic [1:0][19:0] pend;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;

   // model state, index 0 = edge instance, 1 = sticky instance
   int m_st   [2];
   int m_arm  [2];
   int m_pend [2][5];

   always #5 clk = ~clk;

   event_hub #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STICKY(0)) dut_edge (
`ifdef EVENT_HUB_TIMESTAMP_EN
      .done_ts     (e_ts),
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .trig        (trig),
      .wait_valid  (wait_valid),
      .wait_ch     (wait_ch),
      .wait_ready  (e_ready),
      .wait_cancel (wait_cancel),
      .wait_done   (e_done),
      .mon_valid   (e_mv),
      .mon_ch      (e_mch),
      .mon_multi   (e_mm),
      .pending     (e_pend)
   );

   event_hub #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STICKY(1)) dut_sticky (
`ifdef EVENT_HUB_TIMESTAMP_EN
      .done_ts     (s_ts),
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .trig        (trig),
      .wait_valid  (wait_valid),
      .wait_ch     (wait_ch),
      .wait_ready  (s_ready),
      .wait_cancel (wait_cancel),
      .wait_done   (s_done),
      .mon_valid   (s_mv),
      .mon_ch      (s_mch),
      .mon_multi   (s_mm),
      .pending     (s_pend)
   );

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] act,
                              input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the outputs
   // the model predicts after the following rising edge.
   task automatic applyStimulus(input logic r, input logic [4:0] t,
                                input logic v, input logic [2:0] ch,
                                input logic c);
      exp_t e;
      int   old_arm;
      int   p;
      bit   hit;
      bit   cons;
      bit   found;
      @(negedge clk);
      rst_n       = r;
      trig        = t;
      wait_valid  = v;
      wait_ch     = ch;
      wait_cancel = c;
      for (int m = 0; m < 2; m++) begin
         if (!r) begin
            m_st[m]  = 0;
            m_arm[m] = 0;
            for (int i = 0; i < 5; i++) m_pend[m][i] = 0;
         end else begin
            old_arm = m_arm[m];
            hit     = 1'b0;
            cons    = 1'b0;
            if (old_arm < 5) begin
               hit = t[old_arm] || ((m == 1) && (m_pend[m][old_arm] > 0));
            end
            case (m_st[m])
               0: if (v) begin
                     m_st[m]  = 1;
                     m_arm[m] = int'(ch);
                  end
               1: if (c) m_st[m] = 0;
                  else if (hit) begin
                     m_st[m] = 2;
                     cons    = (m == 1);
                  end
               default: m_st[m] = 0;
            endcase
            for (int i = 0; i < 5; i++) begin
               p = m_pend[m][i] + (t[i] ? 1 : 0) - ((cons && i == old_arm) ? 1 : 0);
               if (p > 15) p = 15;
               m_pend[m][i] = p;
            end
         end
         e.ready[m] = (m_st[m] == 0);
         e.done[m]  = (m_st[m] == 2);
         for (int i = 0; i < 5; i++) e.pend[m][i*4 +: 4] = 4'(m_pend[m][i]);
         e.mv[m]  = r && (t != 5'd0);
         e.mm[m]  = r && ($countones(t) > 1);
         e.mch[m] = 3'd0;
         found    = 1'b0;
         if (r) begin
            for (int i = 0; i < 5; i++) begin
               if (t[i] && !found) begin
                  e.mch[m] = 3'(i);
                  found    = 1'b1;
               end
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b1, 5'd0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic afterEdge();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard checker
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         checkOutput("e.ready", 32'(e_ready), 32'(cur.ready[0]));
         checkOutput("e.done",  32'(e_done),  32'(cur.done[0]));
         checkOutput("e.mv",    32'(e_mv),    32'(cur.mv[0]));
         checkOutput("e.mch",   32'(e_mch),   32'(cur.mch[0]));
         checkOutput("e.mm",    32'(e_mm),    32'(cur.mm[0]));
         checkOutput("e.pend",  32'(e_pend),  32'(cur.pend[0]));
         checkOutput("s.ready", 32'(s_ready), 32'(cur.ready[1]));
         checkOutput("s.done",  32'(s_done),  32'(cur.done[1]));
         checkOutput("s.mv",    32'(s_mv),    32'(cur.mv[1]));
         checkOutput("s.mch",   32'(s_mch),   32'(cur.mch[1]));
         checkOutput("s.mm",    32'(s_mm),    32'(cur.mm[1]));
         checkOutput("s.pend",  32'(s_pend),  32'(cur.pend[1]));
      end
   end

   initial begin
      rst_n       = 1'b0;
      trig        = 5'd0;
      wait_valid  = 1'b0;
      wait_ch     = 3'd0;
      wait_cancel = 1'b0;

      // reset, including triggers that must be discarded
      applyStimulus(1'b0, 5'd0,  1'b0, 3'd0, 1'b0);
      applyStimulus(1'b0, 5'h1f, 1'b0, 3'd0, 1'b0);
      afterEdge();
      checkOutput("rst.ready", 32'(s_ready), 32'd1);
      checkOutput("rst.pend",  32'(s_pend),  32'd0);

      // edge mode: trigger in acceptance cycle ignored, later one completes
      idle(2);
      applyStimulus(1'b1, 5'b00001, 1'b1, 3'd0, 1'b0);
      idle(3);
      applyStimulus(1'b1, 5'b00001, 1'b0, 3'd0, 1'b0);
      afterEdge();
      checkOutput("edge.done", 32'(e_done), 32'd1);
      idle(2);

      // sticky: stored triggers complete a wait and one is consumed
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 5'b01000, 1'b0, 3'd0, 1'b0);
      applyStimulus(1'b1, 5'd0, 1'b1, 3'd3, 1'b0);
      applyStimulus(1'b1, 5'd0, 1'b0, 3'd0, 1'b0);
      afterEdge();
      checkOutput("stk.done",  32'(s_done),        32'd1);
      checkOutput("stk.pend3", 32'(s_pend[15:12]), 32'd2);
      applyStimulus(1'b1, 5'd0, 1'b0, 3'd0, 1'b1);

      // monitor with two channels firing
      applyStimulus(1'b1, 5'b10100, 1'b0, 3'd0, 1'b0);
      afterEdge();
      checkOutput("mon.valid", 32'(s_mv),  32'd1);
      checkOutput("mon.ch",    32'(s_mch), 32'd2);
      checkOutput("mon.multi", 32'(s_mm),  32'd1);

      // cancel beats a simultaneous completing trigger
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
      applyStimulus(1'b1, 5'd0, 1'b1, 3'd2, 1'b0);
      applyStimulus(1'b1, 5'b00100, 1'b0, 3'd0, 1'b1);
      afterEdge();
      checkOutput("cnl.ready", 32'(s_ready),     32'd1);
      checkOutput("cnl.done",  32'(s_done),      32'd0);
      checkOutput("cnl.pend2", 32'(s_pend[11:8]), 32'd1);
      idle(1);

      // saturation, drain by 15 waits, then an unsatisfiable wait
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, 5'b00010, 1'b0, 3'd0, 1'b0);
      afterEdge();
      checkOutput("sat.pend1", 32'(s_pend[7:4]), 32'd15);
      for (int k = 0; k < 15; k++) begin
         applyStimulus(1'b1, 5'd0, 1'b1, 3'd1, 1'b0);
         idle(2);
      end
      afterEdge();
      checkOutput("drn.pend1", 32'(s_pend[7:4]), 32'd0);
      applyStimulus(1'b1, 5'd0, 1'b1, 3'd1, 1'b0);
      idle(2);
      afterEdge();
      checkOutput("drn.armed", 32'(s_ready), 32'd0);
      applyStimulus(1'b1, 5'd0, 1'b0, 3'd0, 1'b1);

      // out-of-range channel never completes
      applyStimulus(1'b1, 5'd0, 1'b1, 3'd6, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 5'h1f, 1'b0, 3'd0, 1'b0);
      afterEdge();
      checkOutput("oor.armed", 32'(s_ready), 32'd0);
      applyStimulus(1'b1, 5'd0, 1'b0, 3'd0, 1'b1);

      // reset while armed with pending[4]=7
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 7; k++) applyStimulus(1'b1, 5'b10000, 1'b0, 3'd0, 1'b0);
      applyStimulus(1'b1, 5'd0, 1'b1, 3'd0, 1'b0);
      idle(1);
      afterEdge();
      checkOutput("ra.pend4", 32'(s_pend[19:16]), 32'd7);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
      afterEdge();
      checkOutput("ra.ready", 32'(s_ready), 32'd1);
      checkOutput("ra.pend",  32'(s_pend),  32'd0);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         applyStimulus(($urandom % 50) != 0,
                       (($urandom % 3) == 0) ? 5'($urandom) : 5'd0,
                       ($urandom % 2) == 0,
                       3'($urandom_range(0, 7)),
                       ($urandom % 7) == 0);
      end

      repeat (3) @(posedge clk);
      #2;
      checkOutput("sb.empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
